send_unit: RTL and testbench
============================

SEND_UNIT -- requirements
Module: send_unit

Interface
REQ-001 Parameter NUM_PIXELS, 64, number of bytes read from pixel memory and transmitted per frame (2..2^ADDR_W).
REQ-002 Parameter ADDR_W, 6, pixel memory address width.
REQ-003 Parameter CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 state_send  input  1  level enable from the top-level controller; high while the controller is in its SEND state.
REQ-007 mem_addr  output  ADDR_W  registered read address to the synchronous pixel RAM.
REQ-008 mem_rdata  input  8  RAM read data, valid one cycle after mem_addr is presented.
REQ-009 tx  output  1  registered serial line; idles high.
REQ-010 busy  output  1  high in FETCH and SHIFT states.
REQ-011 done_send  output  1  registered one-cycle completion pulse to the controller.

Function
REQ-012 FSM states SHALL be IDLE, FETCH, SHIFT, DONE, HOLD.
REQ-013 IDLE: tx=1, mem_addr=0, busy=0; when state_send=1 is sampled, next state FETCH with mem_addr=0.
REQ-014 FETCH SHALL last exactly one cycle, presenting mem_addr, then go to SHIFT.
REQ-015 On the FETCH->SHIFT edge the 10-bit frame {stop=1, mem_rdata[7:0], start=0} SHALL be loaded and tx SHALL drive the start bit from that edge.
REQ-016 SHIFT SHALL transmit bits LSB first (start, d0..d7, stop), each held exactly CLKS_PER_BIT cycles, using a bit-time counter and a 4-bit bit index (0..9).
REQ-017 After the stop bit completes: if mem_addr == NUM_PIXELS-1 go to DONE; else mem_addr increments by 1 and go to FETCH.
REQ-018 Each byte SHALL occupy exactly 1 + 10*CLKS_PER_BIT cycles; a frame SHALL occupy NUM_PIXELS*(1 + 10*CLKS_PER_BIT) cycles from first FETCH to DONE (2624 with defaults).
REQ-019 DONE SHALL last one cycle with done_send=1 and tx=1, then go to HOLD.
REQ-020 HOLD: done_send=0, tx=1; remain until state_send=0, then IDLE (no retransmission while state_send stays high).
REQ-021 Abort: if state_send=0 is sampled in FETCH or SHIFT, next state IDLE, tx=1, mem_addr=0, no done_send pulse; partial byte is discarded.
REQ-022 state_send deasserting in the same cycle the last stop bit completes SHALL be treated as abort (no done_send).
REQ-023 mem_addr SHALL never exceed NUM_PIXELS-1; no wrap within a frame.
REQ-024 A new frame SHALL always restart at address 0.

Reset
REQ-025 reset=1 SHALL asynchronously force state IDLE, tx=1, mem_addr=0, busy=0, done_send=0, counters and shift register cleared.
REQ-026 Reset asserted mid-byte SHALL return tx to 1 immediately with no done_send, and the first frame after release SHALL start at address 0.

Verification
REQ-027 Defaults, RAM[i]=i, state_send held high -> 64 frames on tx, byte k decodes to k, done_send single pulse exactly 2624 cycles after first FETCH, then HOLD with tx=1.
REQ-028 RAM[0]=0xA5, CLKS_PER_BIT=4 -> tx sequence 0,1,0,1,0,0,1,0,1,1 each held 4 cycles.
REQ-029 state_send dropped during byte 3 bit 5 -> next cycle IDLE, tx=1, busy=0, no done_send; re-raise -> transmission restarts at mem_addr=0.
REQ-030 After done_send, keep state_send high 100 cycles -> no further tx activity or done_send; drop and re-raise -> new frame from address 0.
REQ-031 Assert reset during byte 10 -> tx=1, mem_addr=0, done_send=0 without clock edge; release with state_send=1 -> full frame from address 0.
REQ-032 NUM_PIXELS=2, CLKS_PER_BIT=1 -> frame of 22 cycles, mem_addr sequence 0,1, done_send pulse on cycle 23.

Source files
------------

// File: rtl/send_unit.sv
// Serial pixel sender: reads NUM_PIXELS bytes from a synchronous pixel RAM and
// shifts each out on tx as start/8 data/stop, pulsing done_send after the last byte.
module send_unit #(
  parameter int NUM_PIXELS   = 64,
  parameter int ADDR_W       = 6,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              state_send,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done_send
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [3:0]        LAST_BIT  = 4'd9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [9:0]        r_shift, w_shift_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [3:0]        r_bit, w_bit_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_bit   <= 4'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic; r_shift[0] is always the bit currently on the line.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = 1'b1;
    case (r_state)
      IDLE: begin
        w_addr_nxt = '0;
        if (state_send) begin
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FETCH: begin
        if (!state_send) begin
          w_state_nxt = IDLE;
          w_addr_nxt  = '0;
        end else begin
          w_state_nxt = SHIFT;
          w_shift_nxt = {1'b1, mem_rdata, 1'b0};
          w_cnt_nxt   = '0;
          w_bit_nxt   = 4'd0;
          w_tx_nxt    = 1'b0;
        end
      end
      SHIFT: begin
        // A drop of state_send wins even on the final stop-bit cycle.
        if (!state_send) begin
          w_state_nxt = IDLE;
          w_addr_nxt  = '0;
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
          w_bit_nxt   = 4'd0;
        end else if (r_cnt != LAST_CNT) begin
          w_cnt_nxt = r_cnt + 1'b1;
          w_tx_nxt  = r_shift[0];
        end else if (r_bit != LAST_BIT) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = r_bit + 4'd1;
          w_shift_nxt = {1'b1, r_shift[9:1]};
          w_tx_nxt    = r_shift[1];
        end else if (r_addr == LAST_ADDR) begin
          w_state_nxt = DONE;
        end else begin
          w_addr_nxt  = r_addr + 1'b1;
          w_state_nxt = FETCH;
        end
      end
      DONE: begin
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (!state_send) begin
          w_state_nxt = IDLE;
          w_addr_nxt  = '0;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_addr_nxt  = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == FETCH) || (w_state_nxt == SHIFT);
    w_done_nxt = (w_state_nxt == DONE);
  end

  assign mem_addr  = r_addr;
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign done_send = r_done;

endmodule

// File: tb/tb_send_unit.sv
// Scoreboard bench for send_unit: a default-parameter instance and a
// NUM_PIXELS=2 / CLKS_PER_BIT=1 instance, with a decoding monitor on tx.
module tb_send_unit;

  typedef struct { int ch; logic [7:0] data; } byte_exp_t;
  typedef struct { int ch; int cyc; } done_exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ss_m, ss_s;
  logic [5:0] addr_m;
  logic [0:0] addr_s;
  logic [7:0] rdata_m = 8'h00;
  logic [7:0] rdata_s = 8'h00;
  logic       tx_m, busy_m, done_m;
  logic       tx_s, busy_s, done_s;

  logic [7:0] ram   [64];
  logic [7:0] ram_s [2];

  byte_exp_t byte_q[$];
  done_exp_t done_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  send_unit u_main (
    .clk(clk), .reset(reset), .state_send(ss_m), .mem_addr(addr_m),
    .mem_rdata(rdata_m), .tx(tx_m), .busy(busy_m), .done_send(done_m)
  );

  send_unit #(.NUM_PIXELS(2), .ADDR_W(1), .CLKS_PER_BIT(1)) u_small (
    .clk(clk), .reset(reset), .state_send(ss_s), .mem_addr(addr_s),
    .mem_rdata(rdata_s), .tx(tx_s), .busy(busy_s), .done_send(done_s)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pixel RAM read lands half a cycle after the address, ready by the end of FETCH.
  always @(negedge clk) begin
    rdata_m <= ram[addr_m];
    rdata_s <= ram_s[addr_s];
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_bytes(input int ch, input int n);
    byte_exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ch   = ch;
      e.data = (ch == 0) ? ram[k] : ram_s[k];
      byte_q.push_back(e);
    end
  endtask

  task automatic push_frame(input int ch, input int n, input int c0);
    done_exp_t d;
    push_bytes(ch, n);
    d.ch  = ch;
    d.cyc = c0 + n * (1 + 10 * ((ch == 0) ? 4 : 1));
    done_q.push_back(d);
  endtask

  task automatic drain(input string nm, input int bound);
    for (int i = 0; i < bound && (byte_q.size() != 0 || done_q.size() != 0); i++) begin
      @(posedge clk);
      #2;
    end
    vec_cnt++;
    if (byte_q.size() != 0 || done_q.size() != 0) begin
      err_cnt++;
      $display("FAIL %s: %0d bytes and %0d done pulses still outstanding, expected none",
               nm, byte_q.size(), done_q.size());
      byte_q.delete();
      done_q.delete();
    end
  endtask

  // Monitor: decodes every byte on both tx lines and checks every done pulse.
  initial begin : monitor
    int         mcnt [2];
    logic       smp  [2][40];
    logic       ctx, cbusy, cdone, held;
    int         cpb;
    logic [7:0] got;
    byte_exp_t  e;
    done_exp_t  d;
    mcnt[0] = 0;
    mcnt[1] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 2; ch++) begin
        ctx   = (ch == 0) ? tx_m : tx_s;
        cbusy = (ch == 0) ? busy_m : busy_s;
        cdone = (ch == 0) ? done_m : done_s;
        cpb   = (ch == 0) ? 4 : 1;
        if (cdone === 1'b1) begin
          vec_cnt++;
          if (done_q.size() == 0) begin
            err_cnt++;
            $display("FAIL done_unexpected: ch %0d pulsed at cycle %0d, expected no pulse", ch, cyc);
          end else begin
            d = done_q.pop_front();
            if (d.ch != ch || d.cyc != cyc) begin
              err_cnt++;
              $display("FAIL done_time: got ch %0d cycle %0d expected ch %0d cycle %0d",
                       ch, cyc, d.ch, d.cyc);
            end
          end
        end
        if (cbusy !== 1'b1) begin
          mcnt[ch] = 0;
        end else if (mcnt[ch] == 0) begin
          if (ctx === 1'b0) begin
            smp[ch][0] = ctx;
            mcnt[ch]   = 1;
          end
        end else begin
          smp[ch][mcnt[ch]] = ctx;
          mcnt[ch]++;
          if (mcnt[ch] == 10 * cpb) begin
            held = 1'b1;
            got  = 8'h00;
            for (int b = 0; b < 10; b++)
              for (int j = 1; j < cpb; j++)
                if (smp[ch][b*cpb+j] !== smp[ch][b*cpb]) held = 1'b0;
            for (int b = 0; b < 8; b++) got[b] = smp[ch][(b+1)*cpb];
            vec_cnt++;
            if (byte_q.size() == 0) begin
              err_cnt++;
              $display("FAIL byte_unexpected: ch %0d byte %02h at cycle %0d, expected none", ch, got, cyc);
            end else begin
              e = byte_q.pop_front();
              if (e.ch != ch || e.data !== got || !held || smp[ch][9*cpb] !== 1'b1) begin
                err_cnt++;
                $display("FAIL byte: got ch %0d %02h held %0b stop %0b expected ch %0d %02h held 1 stop 1",
                         ch, got, held, smp[ch][9*cpb], e.ch, e.data);
              end
            end
            mcnt[ch] = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    err_cnt++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin : stimulus
    int         c0;
    logic       quiet;
    logic [9:0] a5f;
    a5f = 10'b11_0100_1010;
    for (int i = 0; i < 64; i++) ram[i] = 8'(i);
    ram_s[0] = 8'h3C;
    ram_s[1] = 8'hC3;
    ss_m  = 1'b0;
    ss_s  = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check("reset_tx", tx_m, 1'b1);
    check("reset_busy", busy_m, 1'b0);
    check("reset_done", done_m, 1'b0);
    check("reset_addr", addr_m, 6'd0);
    @(negedge clk) reset = 1'b0;
    repeat (2) tick();
    check("idle_tx", tx_m, 1'b1);

    // Full frame with RAM[i]=i.
    @(negedge clk);
    c0 = cyc + 1;
    push_frame(0, 64, c0);
    ss_m = 1'b1;
    wait_until(c0);
    check("fetch0_busy", busy_m, 1'b1);
    check("fetch0_addr", addr_m, 6'd0);
    check("fetch0_tx", tx_m, 1'b1);
    drain("frame_ramp", 3000);

    // HOLD with state_send still high: line stays quiet.
    quiet = 1'b1;
    repeat (100) begin
      tick();
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) quiet = 1'b0;
    end
    check("hold_quiet", quiet, 1'b1);
    @(negedge clk) ss_m = 1'b0;
    repeat (2) tick();
    check("idle_addr", addr_m, 6'd0);

    // A5 waveform, then abort during byte 3 bit 5.
    ram[0] = 8'hA5;
    @(negedge clk);
    c0 = cyc + 1;
    push_bytes(0, 3);
    ss_m = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wait_until(c0 + 1 + i);
      check($sformatf("a5_bit%0d", i / 4), tx_m, a5f[i/4]);
    end
    wait_until(c0 + 3 * 41 + 1 + 5 * 4 + 1);
    @(negedge clk) ss_m = 1'b0;
    tick();
    check("abort_busy", busy_m, 1'b0);
    check("abort_tx", tx_m, 1'b1);
    check("abort_addr", addr_m, 6'd0);
    drain("abort_bytes", 5);
    repeat (3) tick();

    // Re-raise: whole frame again from address 0.
    @(negedge clk);
    c0 = cyc + 1;
    push_frame(0, 64, c0);
    ss_m = 1'b1;
    wait_until(c0);
    check("restart_addr", addr_m, 6'd0);
    drain("frame_restart", 3000);
    @(negedge clk) ss_m = 1'b0;
    repeat (3) tick();

    // Asynchronous reset during byte 10.
    @(negedge clk);
    c0 = cyc + 1;
    push_bytes(0, 10);
    ss_m = 1'b1;
    wait_until(c0 + 10 * 41 + 20);
    #1 reset = 1'b1;
    #1;
    check("areset_tx", tx_m, 1'b1);
    check("areset_addr", addr_m, 6'd0);
    check("areset_done", done_m, 1'b0);
    check("areset_busy", busy_m, 1'b0);
    drain("pre_reset_bytes", 5);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
    c0 = cyc + 1;
    push_frame(0, 64, c0);
    wait_until(c0);
    check("post_reset_addr", addr_m, 6'd0);
    check("post_reset_busy", busy_m, 1'b1);
    drain("frame_after_reset", 3000);
    @(negedge clk) ss_m = 1'b0;
    repeat (3) tick();

    // Two-pixel, one-clock-per-bit instance.
    @(negedge clk);
    c0 = cyc + 1;
    push_frame(1, 2, c0);
    ss_s = 1'b1;
    wait_until(c0);
    check("small_addr0", addr_s, 1'b0);
    wait_until(c0 + 11);
    check("small_addr1", addr_s, 1'b1);
    check("small_busy", busy_s, 1'b1);
    drain("frame_small", 100);
    tick();
    check("small_hold_tx", tx_s, 1'b1);
    check("small_hold_busy", busy_s, 1'b0);
    check("small_hold_done", done_s, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
